// File: rtl/framebuffer_scanout.sv
// Raster-order reader of the pixel memory that generates VGA hsync/vsync/de timing.
// Stage 0 drives the memory read port; stage 1 aligns the syncs with the returned pixel data.
module framebuffer_scanout #(
    parameter int unsigned HOR_ACTIVE_PIXELS = 640,
    parameter int unsigned HOR_FRONT_PORCH   = 16,
    parameter int unsigned HOR_SYNC          = 96,
    parameter int unsigned HOR_BACK_PORCH    = 48,
    parameter int unsigned VER_ACTIVE_PIXELS = 480,
    parameter int unsigned VER_FRONT_PORCH   = 10,
    parameter int unsigned VER_SYNC          = 2,
    parameter int unsigned VER_BACK_PORCH    = 33,
    parameter int unsigned SYNC_ACTIVE_LOW   = 1,
    parameter int unsigned READ_DATA_WIDTH   = 1,
    localparam int unsigned PIX_TOTAL = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
    localparam int unsigned ADDR_W    = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       read_enable,
    output logic [ADDR_W-1:0]          read_addr,
    input  logic [READ_DATA_WIDTH-1:0] read_data,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       de,
    output logic [READ_DATA_WIDTH-1:0] pixel,
    output logic                       vblank,
    output logic                       frame_done
);

    localparam int unsigned H_TOTAL  = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH;
    localparam int unsigned V_TOTAL  = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC + VER_BACK_PORCH;
    localparam int unsigned H_W      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned V_W      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned HS_START = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH;
    localparam int unsigned HS_END   = HS_START + HOR_SYNC;
    localparam int unsigned VS_START = VER_ACTIVE_PIXELS + VER_FRONT_PORCH;
    localparam int unsigned VS_END   = VS_START + VER_SYNC;
    localparam logic        SYNC_ON  = (SYNC_ACTIVE_LOW == 0);

    logic [H_W-1:0]    h_cnt_q, h_cnt_d;
    logic [V_W-1:0]    v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              de_q;
    logic              frame_done_q;

    logic [31:0] h_ext, v_ext;
    logic        active, last_pix;

    assign h_ext = 32'(h_cnt_q);
    assign v_ext = 32'(v_cnt_q);

    always_comb begin
        active   = (h_ext < HOR_ACTIVE_PIXELS) && (v_ext < VER_ACTIVE_PIXELS);
        last_pix = (h_ext == HOR_ACTIVE_PIXELS - 1) && (v_ext == VER_ACTIVE_PIXELS - 1);

        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (h_ext == H_TOTAL - 1) begin
            h_cnt_d = '0;
            v_cnt_d = (v_ext == V_TOTAL - 1) ? '0 : v_cnt_q + 1'b1;
        end else begin
            h_cnt_d = h_cnt_q + 1'b1;
        end

        // Address follows the raster by incrementing; wrap is keyed on position, not address.
        addr_d = addr_q;
        if (active) begin
            addr_d = last_pix ? '0 : addr_q + 1'b1;
        end

        hsync_d = ((h_ext >= HS_START) && (h_ext < HS_END)) ? SYNC_ON : ~SYNC_ON;
        vsync_d = ((v_ext >= VS_START) && (v_ext < VS_END)) ? SYNC_ON : ~SYNC_ON;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            addr_q       <= '0;
            hsync_q      <= ~SYNC_ON;
            vsync_q      <= ~SYNC_ON;
            de_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            addr_q       <= addr_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            de_q         <= active;
            frame_done_q <= last_pix;
        end
    end

    // Counters already sit at (0,0) during reset, so stage-0 outputs are gated by rst explicitly.
    always_comb begin
        read_enable = active && !rst;
        read_addr   = (active && !rst) ? addr_q : '0;
        vblank      = (v_ext >= VER_ACTIVE_PIXELS) && !rst;
        hsync       = hsync_q;
        vsync       = vsync_q;
        de          = de_q;
        frame_done  = frame_done_q;
        pixel       = de_q ? read_data : '0;
    end

endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
Reader side of the framebuffer: walks the pixel memory in raster order and drives VGA timing (hsync, vsync, data enable) plus pixel colour to the video output. The line drawer and other writers fill the memory through its write port. This block owns the read port. It also tells writers when vertical blanking is in progress and when each frame has finished scanning.

Parameters:
HOR_ACTIVE_PIXELS, 640, visible pixels per line
HOR_FRONT_PORCH, 16, clocks between active end and hsync
HOR_SYNC, 96, hsync width in clocks
HOR_BACK_PORCH, 48, clocks between hsync end and next line
VER_ACTIVE_PIXELS, 480, visible lines per frame
VER_FRONT_PORCH, 10, lines between active end and vsync
VER_SYNC, 2, vsync width in lines
VER_BACK_PORCH, 33, lines between vsync end and next frame
SYNC_ACTIVE_LOW, 1, 1 = syncs low when asserted, 0 = high
READ_DATA_WIDTH, 1, bits per pixel (matches writer WRITE_DATA_WIDTH)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
read_enable  out  1  memory read strobe
read_addr  out  clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)  pixel address, y*HOR_ACTIVE_PIXELS+x
read_data  in  READ_DATA_WIDTH  memory data, valid exactly 1 clk after read_enable
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  data enable (visible pixel)
pixel  out  READ_DATA_WIDTH  colour; 0 when de=0
vblank  out  1  high while v_count >= VER_ACTIVE_PIXELS
frame_done  out  1  one-clk pulse on last visible pixel of frame

Behaviour:
- H_TOTAL = sum of the four HOR_* parameters. V_TOTAL = sum of the four VER_* parameters.
- Stage 0 state:
  - h_count runs 0..H_TOTAL-1 and wraps to 0.
  - v_count increments when h_count wraps, runs 0..V_TOTAL-1, and wraps to 0.
  - addr_count holds the current read address.
- active = h_count < HOR_ACTIVE_PIXELS and v_count < VER_ACTIVE_PIXELS.
- Stage 0 combinational outputs:
  - read_enable = active.
  - read_addr = addr_count when active, else 0.
  - vblank = (v_count >= VER_ACTIVE_PIXELS).
  - All three are forced to 0 while rst is high.
- addr_count:
  - Increments on every active clock.
  - Returns to 0 after the last visible pixel (h=HOR_ACTIVE_PIXELS-1, v=VER_ACTIVE_PIXELS-1).
  - Never exceeds HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS-1.
  - No multiplier is permitted.
- Syncs:
  - hsync is asserted for HOR_ACTIVE_PIXELS+HOR_FRONT_PORCH <= h_count < that value + HOR_SYNC.
  - vsync is asserted by the same rule on v_count with the VER_* parameters.
  - Asserted level = !SYNC_ACTIVE_LOW.
- Stage 1 (registered, 1 clk latency):
  - hsync, vsync and de are registered copies of the stage-0 values.
  - pixel = de ? read_data : 0, combinational from registered de and memory data.
  - Result: pixel, de, hsync and vsync are mutually aligned.
- frame_done: registered, high for exactly the clock in which de is high for address HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS-1.
- Reset (asynchronous, no clock needed):
  - Counters and addr_count go to 0.
  - de=0, pixel=0, frame_done=0.
  - hsync and vsync go to their deasserted level.
  - read_enable=0, vblank=0.
  - First rising edge after release sees counters at (0,0): read_enable=1 and read_addr=0 in that clock; de=1 the next clock.
- Reset mid-frame: scan abandons and restarts at (0,0), address 0. No partial-line continuation.
- Writers are not arbitrated here. Memory is dual-port; read port latency is fixed at 1.

Test Plan:
Small parameters for all tests: HOR 8/2/3/1 (H_TOTAL=14), VER 4/1/2/1 (V_TOTAL=8), SYNC_ACTIVE_LOW=1, READ_DATA_WIDTH=1.
1. Reset/start: hold rst, then release -> while rst is high, hsync=vsync=1, de=0, pixel=0, read_enable=0. After release: read_enable=1, read_addr=0 on the first clock; de=1 on the second.
2. Horizontal timing -> read_enable high for h=0..7; hsync low exactly 3 clks starting 11 clks after line start (h=10..12 plus 1 clk latency); lines repeat every 14 clks.
3. Addressing: memory model read_data=addr[0] -> read_addr sequence is 0..7 on line 0 and 8..15 on line 1; last address is 31 on line 3; next frame restarts at 0. pixel sequence 0,1,0,1,... aligned with de.
4. Vertical/status -> vsync low for lines 5-6 only (28 clks); vblank high for lines 4-7; frame_done is a single pulse every 112 clks, coincident with the de clock of address 31.
5. Async reset mid-line: assert rst between edges at h=5,v=2 -> outputs take reset values immediately with no clock edge; after release, read_addr restarts at 0 and h/v restart at 0.
6. Blanking masking: read_data tied to 1 -> pixel=1 only when de=1, and pixel=0 in every porch and sync clock.
